// File: rtl/xadc_mv_bcd.sv
// xadc_mv_bcd: one raw XADC DRP sample -> 4-digit packed-BCD millivolts (scale step, then double-dabble).
// Optional build macro XADC_ROUND_EN: round-half-up scaling; default build truncates.
module xadc_mv_bcd #(
  parameter int FULL_SCALE_MV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic        overrange
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCALE  = 2'd1;
  localparam logic [1:0] S_DABBLE = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [13:0] FS_MV  = 14'(FULL_SCALE_MV);
  localparam logic [13:0] MV_MAX = 14'd9999;
`ifdef XADC_ROUND_EN
  localparam logic [25:0] RND = 26'd2048;
`else
  localparam logic [25:0] RND = 26'd0;
`endif

  // {bcd[15:0], binary[13:0]}: add 3 to each BCD nibble >= 5, then shift left by one
  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] a;
    a = s;
    for (int i = 0; i < 4; i++) begin
      a[14+4*i +: 4] = (a[14+4*i +: 4] >= 4'd5) ? (a[14+4*i +: 4] + 4'd3) : a[14+4*i +: 4];
    end
    return a << 1;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [11:0] code_q, code_d;
  logic [29:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovr_q, ovr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] dout_q, dout_d;
  logic        overrange_q, overrange_d;
  logic [25:0] prod_s;
  logic [13:0] mv_s;
  logic        din_unused_s;

  assign din_unused_s = ^din[3:0];

  // Next-state and datapath logic for the scale / dabble / finish sequence
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dout_d      = dout_q;
    overrange_d = overrange_q;
    prod_s      = 26'(code_q) * 26'(FS_MV);
    mv_s        = 14'((prod_s + RND) >> 5'd12);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d  = din[15:4];
          busy_d  = 1'b1;
          state_d = S_SCALE;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SCALE: begin
        // Overrange still walks the dabble steps so latency stays fixed
        ovr_d   = (mv_s > MV_MAX);
        shreg_d = {16'd0, mv_s};
        cnt_d   = 4'd14;
        state_d = S_DABBLE;
      end
      S_DABBLE: begin
        shreg_d = dabble_step(shreg_q);
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_DABBLE;
        end
      end
      S_FINISH: begin
        dout_d      = ovr_q ? 16'h9999 : shreg_q[29:14];
        overrange_d = ovr_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      code_q      <= 12'd0;
      shreg_q     <= 30'd0;
      cnt_q       <= 4'd0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= 16'h0000;
      overrange_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      overrange_q <= overrange_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dout      = dout_q;
  assign overrange = overrange_q;

endmodule
